// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and constants for the register file writeback path
package regfile_pkg;

  localparam int XLEN     = 32;
  localparam int RADDR_W  = 5;
  localparam int NUM_REGS = 32;

  typedef struct packed {
    logic               valid;
    logic [RADDR_W-1:0] addr;
    logic [XLEN-1:0]    data;
  } wb_req_t;

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_LSU = 1'b1
  } wb_src_e;

  function automatic logic is_x0(input logic [RADDR_W-1:0] addr);
    return addr == '0;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin arbiter; the last grant only moves on a real grant
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  wb_src_e last_grant_q, last_grant_d;

  always_comb begin
    gnt          = 2'b00;
    last_grant_d = last_grant_q;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_grant_q == GNT_LSU) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
    if (gnt[0]) begin
      last_grant_d = GNT_ALU;
    end else if (gnt[1]) begin
      last_grant_d = GNT_LSU;
    end
  end

  // Reset to LSU so the ALU path wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= GNT_LSU;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the register file write port between ALU and load writeback
// Optional macro WB_FWD_EN adds a bypass view of the in-flight write for decode.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int XLEN    = regfile_pkg::XLEN,
  parameter int RADDR_W = regfile_pkg::RADDR_W,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hold,
`ifdef WB_FWD_EN
  input  logic [RADDR_W-1:0] fwd_raddr1,
  input  logic [RADDR_W-1:0] fwd_raddr2,
  output logic               fwd_hit1,
  output logic               fwd_hit2,
  output logic [XLEN-1:0]    fwd_data,
`endif
  input  logic               req0_valid,
  input  logic [RADDR_W-1:0] req0_addr,
  input  logic [XLEN-1:0]    req0_data,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [RADDR_W-1:0] req1_addr,
  input  logic [XLEN-1:0]    req1_data,
  output logic               req1_ready,
  output logic               reg_wr,
  output logic [RADDR_W-1:0] waddr,
  output logic [XLEN-1:0]    wb_data,
  output logic [CNT_W-1:0]   conflict_cnt
);

  wb_req_t            req0, req1, win;
  wb_src_e            src;
  logic [1:0]         gnt;
  logic               arb_en;
  logic               accept;

  logic               reg_wr_q, reg_wr_d;
  logic [RADDR_W-1:0] waddr_q, waddr_d;
  logic [XLEN-1:0]    wb_data_q, wb_data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  assign arb_en = ~hold & ~reset;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({req1_valid, req0_valid}),
    .en    (arb_en),
    .gnt   (gnt)
  );

  assign req0_ready = gnt[0] & ~hold & ~reset;
  assign req1_ready = gnt[1] & ~hold & ~reset;
  assign accept     = req0_ready | req1_ready;
  assign src        = req1_ready ? GNT_LSU : GNT_ALU;

  always_comb begin
    req0.valid = req0_valid;
    req0.addr  = req0_addr;
    req0.data  = req0_data;
    req1.valid = req1_valid;
    req1.addr  = req1_addr;
    req1.data  = req1_data;
    win        = (src == GNT_LSU) ? req1 : req0;
  end

  always_comb begin
    reg_wr_d  = 1'b0;
    waddr_d   = waddr_q;
    wb_data_d = wb_data_q;
    cnt_d     = cnt_q;
    // x0 requests complete the handshake but never reach the register file.
    if (accept) begin
      reg_wr_d  = win.valid & ~is_x0(win.addr);
      waddr_d   = win.addr;
      wb_data_d = win.data;
    end
    if (req0_valid && req1_valid && !hold && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_wr_q  <= 1'b0;
      waddr_q   <= '0;
      wb_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      reg_wr_q  <= reg_wr_d;
      waddr_q   <= waddr_d;
      wb_data_q <= wb_data_d;
      cnt_q     <= cnt_d;
    end
  end

  assign reg_wr       = reg_wr_q;
  assign waddr        = waddr_q;
  assign wb_data      = wb_data_q;
  assign conflict_cnt = cnt_q;

`ifdef WB_FWD_EN
  assign fwd_hit1 = reg_wr_q & (waddr_q == fwd_raddr1) & (waddr_q != '0);
  assign fwd_hit2 = reg_wr_q & (waddr_q == fwd_raddr2) & (waddr_q != '0);
  assign fwd_data = wb_data_q;
`endif

endmodule
